// File: rtl/fifo_wptr_gray_gen.sv
// Write-side pointer and full/almost-full generator for a dual-clock FIFO.
// Keeps the binary write pointer, publishes a registered Gray copy to the
// read domain, and compares against a two-flop-synchronised read Gray
// pointer to produce registered full, almost_full and sticky overflow.
module fifo_wptr_gray_gen #(
    parameter int ADDR_WIDTH = 5,
    parameter int AF_LEVEL   = 28
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH:0]   rd_gptr_async,
    input  logic                  overflow_clr,
    output logic                  wr_accept,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH:0]   wr_gptr,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow
);

    localparam int PW  = ADDR_WIDTH + 1;
    localparam int MSB = ADDR_WIDTH;
    localparam logic [PW-1:0] AF_LEVEL_C = PW'(AF_LEVEL);

    logic [PW-1:0] wbin_r;
    logic [PW-1:0] rq1_r;
    logic [PW-1:0] rq2_r;
    logic [PW-1:0] wbin_next_s;
    logic [PW-1:0] wgray_next_s;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] occ_next_s;
    logic [PW-1:0] full_match_s;
    logic          full_next_s;
    logic          af_next_s;
    logic          ovf_next_s;

    // Binary to reflected Gray code.
    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: each bit is the XOR of itself and all higher Gray bits.
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b = g;
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // A write is dropped whenever the registered full flag is set.
    assign wr_accept = wr_en & ~full;
    assign wr_addr   = wbin_r[ADDR_WIDTH-1:0];

    // Next-state pointer, occupancy and status terms.
    always_comb begin
        wbin_next_s  = wbin_r + {{(PW-1){1'b0}}, wr_accept};
        wgray_next_s = bin2gray(wbin_next_s);
        rbin_s       = gray2bin(rq2_r);
        occ_next_s   = wbin_next_s - rbin_s;
        // Full when the write pointer is exactly one lap ahead: top two Gray
        // bits inverted relative to the read pointer, the rest equal.
        full_match_s = {~rq2_r[MSB:MSB-1], rq2_r[MSB-2:0]};
        full_next_s  = (wgray_next_s == full_match_s);
        af_next_s    = (occ_next_s >= AF_LEVEL_C);
        if (overflow_clr) begin
            ovf_next_s = 1'b0;
        end else begin
            ovf_next_s = overflow | (wr_en & full);
        end
    end

    // Read-pointer synchroniser: two plain flops, no logic between them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rq1_r <= {PW{1'b0}};
            rq2_r <= {PW{1'b0}};
        end else begin
            rq1_r <= rd_gptr_async;
            rq2_r <= rq1_r;
        end
    end

    // Pointer and status registers; all outputs except wr_accept are flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin_r      <= {PW{1'b0}};
            wr_gptr     <= {PW{1'b0}};
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            wbin_r      <= wbin_next_s;
            wr_gptr     <= wgray_next_s;
            full        <= full_next_s;
            almost_full <= af_next_s;
            overflow    <= ovf_next_s;
        end
    end

endmodule

// File: tb/tb_fifo_wptr_gray_gen.sv
// Bench for fifo_wptr_gray_gen: an occupancy-counting model checked every
// cycle, plus directed literal expectations from hand-worked sequences.
module tb_fifo_wptr_gray_gen;

    localparam int AW    = 5;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 32;
    localparam int AFL   = 28;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [PW-1:0] rd_gptr_async;
    logic          overflow_clr;
    logic          wr_accept;
    logic [AW-1:0] wr_addr;
    logic [PW-1:0] wr_gptr;
    logic          full;
    logic          almost_full;
    logic          overflow;

    int pass_cnt = 0;
    int total_cnt = 0;
    int rd_cnt = 0;

    fifo_wptr_gray_gen #(.ADDR_WIDTH(AW), .AF_LEVEL(AFL)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_gptr_async(rd_gptr_async),
        .overflow_clr(overflow_clr), .wr_accept(wr_accept), .wr_addr(wr_addr),
        .wr_gptr(wr_gptr), .full(full), .almost_full(almost_full), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PW-1:0] gray_of(input int b);
        logic [PW-1:0] x;
        x = b[PW-1:0];
        return x ^ (x >> 1);
    endfunction

    assign rd_gptr_async = gray_of(rd_cnt);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // Model: counts accepted writes and reads as plain integers; the read
    // count seen by the write side lags the driven one by two clock edges.
    int   m_wcnt, m_seen1, m_seen2, m_nw, m_occ;
    logic m_full, m_af, m_ovf;

    assign m_nw  = m_wcnt + ((wr_en && !m_full) ? 1 : 0);
    assign m_occ = m_nw - m_seen2;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wcnt  <= 0;
            m_seen1 <= 0;
            m_seen2 <= 0;
            m_full  <= 1'b0;
            m_af    <= 1'b0;
            m_ovf   <= 1'b0;
        end else begin
            m_wcnt  <= m_nw;
            m_full  <= (m_occ == DEPTH);
            m_af    <= (m_occ >= AFL);
            m_ovf   <= overflow_clr ? 1'b0 : (m_ovf | (wr_en & m_full));
            m_seen2 <= m_seen1;
            m_seen1 <= rd_cnt;
        end
    end

    // Per-cycle compare against the model, plus a single-bit-step check.
    logic [PW-1:0] prev_g;
    always @(negedge clk) begin
        chk("wr_gptr", 32'(wr_gptr), 32'(gray_of(m_wcnt)));
        chk("wr_addr", 32'(wr_addr), 32'(m_wcnt % DEPTH));
        chk("full", 32'(full), 32'(m_full));
        chk("almost_full", 32'(almost_full), 32'(m_af));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("wr_accept", 32'(wr_accept), 32'(wr_en & ~m_full));
        if (!rst_n) begin
            prev_g <= '0;
        end else begin
            if (wr_gptr != prev_g) chk("gray_step", 32'($countones(wr_gptr ^ prev_g)), 32'd1);
            prev_g <= wr_gptr;
        end
    end

    // Drive inputs for one clock edge, then return just after that edge.
    task automatic cyc(input logic en, input logic clr);
        wr_en = en;
        overflow_clr = clr;
        @(posedge clk);
        #2;
    endtask

    initial begin
        int wn;
        rst_n = 1'b0;
        wr_en = 1'b0;
        overflow_clr = 1'b0;
        rd_cnt = 0;
        #23 rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Reset state holds for 10 idle cycles.
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0);
            chk("rst_gptr", 32'(wr_gptr), 32'h0);
            chk("rst_flags", 32'({full, almost_full, overflow}), 32'h0);
        end
        chk("rst_addr", 32'(wr_addr), 32'h0);

        // Fill with 32 writes, read pointer at 0.
        for (int n = 1; n <= 32; n++) begin
            cyc(1'b1, 1'b0);
            if (n == 1) chk("g1", 32'(wr_gptr), 32'h01);
            if (n == 2) chk("g2", 32'(wr_gptr), 32'h03);
            if (n == 3) chk("g3", 32'(wr_gptr), 32'h02);
            if (n == 4) chk("g4", 32'(wr_gptr), 32'h06);
            if (n == 8) chk("g8", 32'(wr_gptr), 32'h0C);
            if (n == 27) chk("af27", 32'(almost_full), 32'h0);
            if (n == 28) chk("af28", 32'(almost_full), 32'h1);
            if (n == 31) chk("full31", 32'(full), 32'h0);
            if (n == 32) chk("full32", 32'(full), 32'h1);
            if (n == 32) chk("g32", 32'(wr_gptr), 32'h30);
        end
        wr_en = 1'b1;
        #1 chk("acc_full", 32'(wr_accept), 32'h0);

        // Writes while full are dropped and set overflow.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
        chk("ovf_set", 32'(overflow), 32'h1);
        chk("ovf_gptr", 32'(wr_gptr), 32'h30);
        chk("ovf_addr", 32'(wr_addr), 32'h0);
        cyc(1'b0, 1'b1);
        chk("ovf_clr", 32'(overflow), 32'h0);
        cyc(1'b1, 1'b1);
        chk("ovf_clr_wins", 32'(overflow), 32'h0);
        cyc(1'b0, 1'b0);
        chk("ovf_stay0", 32'(overflow), 32'h0);

        // Read pointer to Gray(4): full falls on the third edge.
        rd_cnt = 4;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk("full_e2", 32'(full), 32'h1);
        cyc(1'b0, 1'b0);
        chk("full_e3", 32'(full), 32'h0);
        chk("af_occ28", 32'(almost_full), 32'h1);

        // Read pointer to Gray(8): almost_full falls three edges later.
        rd_cnt = 8;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk("af_e2", 32'(almost_full), 32'h1);
        cyc(1'b0, 1'b0);
        chk("af_e3", 32'(almost_full), 32'h0);

        // 64 writes with a trailing read side; pointer wraps 63 -> 0.
        wn = 32;
        for (int i = 0; i < 64; i++) begin
            if (wn - rd_cnt > 20) rd_cnt = rd_cnt + 1;
            cyc(1'b1, 1'b0);
            wn++;
            chk("wrap_nofull", 32'(full), 32'h0);
            if (wn == 63) chk("wrap_g63", 32'(wr_gptr), 32'h20);
            if (wn == 64) chk("wrap_g64", 32'(wr_gptr), 32'h00);
        end
        chk("wrap_g96", 32'(wr_gptr), 32'(6'h30));

        // Short asynchronous reset pulse in the middle of a burst.
        wr_en = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b0;
        rd_cnt = 0;
        #1;
        chk("arst_gptr", 32'(wr_gptr), 32'h0);
        chk("arst_addr", 32'(wr_addr), 32'h0);
        chk("arst_flags", 32'({full, almost_full, overflow}), 32'h0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #2;
        chk("resume_g1", 32'(wr_gptr), 32'h01);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);
        chk("resume_g5", 32'(wr_gptr), 32'h07);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fifo_wptr_gray_gen.md
Name: fifo_wptr_gray_gen

Overview:
Write-side pointer and full-flag generator for the dual-clock frame buffers in the frame formatter. It maintains the binary write pointer and encodes it to a registered Gray-code pointer for the read clock domain. It synchronises the read domain's Gray pointer into this domain and derives registered full, almost-full and overflow status. It is the binary-to-Gray (transmit) counterpart of the read-side Gray-to-binary pointer decode.

Parameters:
ADDR_WIDTH, 5, FIFO address width; DEPTH = 2**ADDR_WIDTH entries; pointers are ADDR_WIDTH+1 bits (default 6).
AF_LEVEL, 28, occupancy at or above which almost_full asserts; legal range 1..DEPTH.

Ports:
clk  input  1  write-domain clock
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  write request from the agent
rd_gptr_async  input  ADDR_WIDTH+1  read-domain Gray pointer, asynchronous to clk
overflow_clr  input  1  synchronous clear of the sticky overflow flag
wr_accept  output  1  combinational, wr_en & ~full; this is the RAM write strobe
wr_addr  output  ADDR_WIDTH  RAM write address, equal to the low bits of the binary pointer
wr_gptr  output  ADDR_WIDTH+1  registered Gray write pointer, sent to the read domain
full  output  1  registered FIFO-full flag
almost_full  output  1  registered, occupancy >= AF_LEVEL
overflow  output  1  sticky flag, set by a write attempt while full

Behaviour:
- Reset (async assert, sync deassert handled upstream): wbin=0, wr_gptr=0, both synchroniser stages=0, full=0, almost_full=0, overflow=0.
- Synchroniser: 2-flop, rq1 <= rd_gptr_async, rq2 <= rq1. No logic between the stages.
- Pointer update:
  - wbin_next = wbin + wr_accept, modulo 2**(ADDR_WIDTH+1).
  - wgray_next = wbin_next ^ (wbin_next >> 1).
  - wbin <= wbin_next and wr_gptr <= wgray_next, every cycle.
  - wr_gptr changes by exactly one bit per accepted write and is glitch-free, being a direct flop output.
- wr_addr = wbin[ADDR_WIDTH-1:0].
- full <= (wgray_next == {~rq2[MSB:MSB-1], rq2[MSB-2:0]}); the top two bits are inverted and the rest are equal.
  - full is set in the same edge as the write that fills the FIFO.
  - full is never a combinational output.
- Occupancy:
  - rbin_s = Gray-to-binary of rq2 (bit i = XOR of rq2 bits i..MSB).
  - occ_next = (wbin_next - rbin_s) mod 2**(ADDR_WIDTH+1), range 0..DEPTH.
  - almost_full <= (occ_next >= AF_LEVEL).
- Overflow:
  - overflow <= overflow_clr ? 0 : (overflow | (wr_en & full)).
  - If clear and a new violation occur in the same cycle, the clear wins.
  - A write attempted while full is dropped: no pointer change, no RAM strobe.
- Latency:
  - A write is visible on wr_gptr 1 cycle after the accepting edge.
  - A read-pointer change is visible on full/almost_full 3 clk edges after it is stable at the input (2 sync + 1 register).
  - Status is therefore pessimistic: full may stay high longer than necessary, but is never deasserted early.
- Wrap-around: wbin rolls from 2**(ADDR_WIDTH+1)-1 to 0. The MSB distinguishes full from empty; no special case is needed.
- Simultaneous events:
  - A write on the cycle rq2 advances uses the new rq2 in the next-state compare.
  - With AF_LEVEL = DEPTH, almost_full and full assert on the same edge.
- Reset mid-operation: all state clears immediately. The read side must be reset in the same event; this block does not track a partner reset.

Test Plan:
- Reset, with rd_gptr_async=0 and wr_en=0 -> wr_gptr=0, wr_addr=0, full=0, almost_full=0, overflow=0; all stay stable for 10 cycles.
- 32 consecutive wr_en with rd pointer held at 0:
  - wr_gptr sequence is 0,1,3,2,6,7,5,4,12,...; a bench checker confirms exactly one bit changes per write.
  - almost_full rises on the edge of the 28th write and full rises on the edge of the 32nd write (wr_gptr=0x30).
  - wr_accept is low from the following cycle.
- Full FIFO, wr_en held for 3 cycles -> wbin and wr_gptr unchanged, wr_accept=0, overflow=1; with wr_en=0, overflow_clr=1 for one cycle -> overflow=0; overflow_clr=1 together with wr_en=1 while full -> overflow=0.
- Full FIFO at wr_gptr=0x30, then rd_gptr_async driven to Gray(4)=0x06 -> full falls on the 3rd clk edge, with occupancy 28 so almost_full stays 1. rd_gptr_async=Gray(8)=0x0C -> almost_full falls 3 edges later.
- Wrap: 64 writes with rd_gptr_async advanced by a model read side (occupancy below 32) -> wbin wraps 63->0 and wr_gptr goes 0x20->0x00; full is never asserted falsely.
- rst_n pulsed low mid-burst for less than one clk period, asynchronous to clk -> outputs clear immediately without waiting for an edge and resume from 0 after deassert.
